// File: rtl/gray_step_tracker_pkg.sv
// Shared types, default widths and a Gray-to-binary helper for the Gray step tracker.
package gray_pkg;

  localparam int unsigned GRAY_W     = 4;
  localparam int unsigned GRAY_PW    = 16;
  localparam int unsigned GRAY_EW    = 8;
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Zero-extend narrower codes into GRAY_MAX_W; the leading zeros decode to zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_tracker_if.sv
// Sample-in / tracked-position-out bundle between a Gray source and the tracker.
interface gray_step_tracker_if
  import gray_pkg::*;
#(
  parameter int unsigned W  = GRAY_W,
  parameter int unsigned PW = GRAY_PW,
  parameter int unsigned EW = GRAY_EW
);

  logic          g_valid;
  logic [W-1:0]  g_in;
  logic          clr_err;
  logic          b_valid;
  logic [W-1:0]  b_out;
  logic          dir_up;
  logic          step_err;
  logic [PW-1:0] pos;
  logic [EW-1:0] err_cnt;

  modport master (
    output g_valid, g_in, clr_err,
    input  b_valid, b_out, dir_up, step_err, pos, err_cnt
  );

  modport slave (
    input  g_valid, g_in, clr_err,
    output b_valid, b_out, dir_up, step_err, pos, err_cnt
  );

endinterface

// File: rtl/gray_step_tracker_gray_to_bin.sv
// Combinational W-bit Gray-to-binary decoder (prefix XOR from the MSB down).
module gray_to_bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin_c
);

  always_comb begin
    o_bin_c        = '0;
    o_bin_c[W-1]   = i_gray[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      o_bin_c[i] = o_bin_c[i+1] ^ i_gray[i];
    end
  end

endmodule

// File: rtl/gray_step_tracker.sv
// Decodes a Gray sample stream, checks single-step moves and tracks a signed position.
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int unsigned W  = GRAY_W,
  parameter int unsigned PW = GRAY_PW,
  parameter int unsigned EW = GRAY_EW
) (
  input  logic              clk,
  input  logic              rst,
  gray_step_tracker_if.slave bus
);

  localparam logic [W-1:0] DELTA_UP   = W'(1);
  localparam logic [W-1:0] DELTA_DOWN = {W{1'b1}};

  state_e        r_state;
  state_e        w_state_nxt;

  logic          r_v1;
  logic [W-1:0]  r_g_q;
  logic [W-1:0]  r_b_prev;
  logic          r_b_valid;
  logic [W-1:0]  r_b_out;
  logic          r_dir_up;
  logic          r_step_err;
  logic [PW-1:0] r_pos;
  logic [EW-1:0] r_err_cnt;

  logic [W-1:0]  w_bn;
  logic [W-1:0]  w_delta;
  logic [W-1:0]  w_b_prev_nxt;
  logic          w_b_valid_nxt;
  logic [W-1:0]  w_b_out_nxt;
  logic          w_dir_up_nxt;
  logic          w_step_err_nxt;
  logic [PW-1:0] w_pos_nxt;
  logic [EW-1:0] w_err_cnt_nxt;

  gray_to_bin #(.W(W)) u_dec (
    .i_gray  (r_g_q),
    .o_bin_c (w_bn)
  );

  assign w_delta = w_bn - r_b_prev;

  // Stage 1: capture the incoming sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_g_q <= '0;
    end else begin
      r_v1 <= bus.g_valid;
      if (bus.g_valid) begin
        r_g_q <= bus.g_in;
      end
    end
  end

  // Stage 2 / tracker: state and every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_b_prev   <= '0;
      r_b_valid  <= 1'b0;
      r_b_out    <= '0;
      r_dir_up   <= 1'b0;
      r_step_err <= 1'b0;
      r_pos      <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_b_prev   <= w_b_prev_nxt;
      r_b_valid  <= w_b_valid_nxt;
      r_b_out    <= w_b_out_nxt;
      r_dir_up   <= w_dir_up_nxt;
      r_step_err <= w_step_err_nxt;
      r_pos      <= w_pos_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_b_prev_nxt   = r_b_prev;
    w_b_valid_nxt  = 1'b0;
    w_b_out_nxt    = r_b_out;
    w_dir_up_nxt   = r_dir_up;
    w_step_err_nxt = r_step_err;
    w_pos_nxt      = r_pos;
    w_err_cnt_nxt  = r_err_cnt;

    // Every sample is decoded and becomes the reference, whatever the state.
    if (r_v1) begin
      w_b_valid_nxt = 1'b1;
      w_b_out_nxt   = w_bn;
      w_b_prev_nxt  = w_bn;
    end

    // A clear overrides classification of a coincident sample.
    if (bus.clr_err) begin
      w_state_nxt    = INIT;
      w_step_err_nxt = 1'b0;
      w_err_cnt_nxt  = '0;
    end else if (r_v1) begin
      unique case (r_state)
        INIT: begin
          w_state_nxt = TRACK;
        end
        TRACK: begin
          if (w_delta == DELTA_UP) begin
            w_pos_nxt    = r_pos + PW'(1);
            w_dir_up_nxt = 1'b1;
          end else if (w_delta == DELTA_DOWN) begin
            w_pos_nxt    = r_pos - PW'(1);
            w_dir_up_nxt = 1'b0;
          end else if (w_delta != '0) begin
            w_step_err_nxt = 1'b1;
            w_err_cnt_nxt  = (r_err_cnt == {EW{1'b1}}) ? r_err_cnt : r_err_cnt + EW'(1);
            w_state_nxt    = FAULT;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = INIT;
        end
      endcase
    end
  end

  assign bus.b_valid  = r_b_valid;
  assign bus.b_out    = r_b_out;
  assign bus.dir_up   = r_dir_up;
  assign bus.step_err = r_step_err;
  assign bus.pos      = r_pos;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed and random checks of gray_step_tracker against a cycle-level reference model.
module tb_gray_step_tracker;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned EW = 8;
  localparam int          M  = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_step_tracker_if #(.W(W), .PW(PW), .EW(EW)) bus ();

  gray_step_tracker #(.W(W), .PW(PW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_err = 0;
  int n_chk = 0;
  int bv_count = 0;

  // Reference model: a pending sample plus the tracked quantities as plain integers.
  int p_valid, p_g;
  int m_prev, m_have_ref, m_faulted;
  int m_pos, m_err, m_step_err, m_dir, m_bout, m_bvalid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Decode by inverting the encoder: find the binary value whose Gray code matches.
  function automatic int decode(input int g);
    for (int b = 0; b < M; b++) begin
      if (gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic model(input bit r, input bit gv, input int g, input bit clr);
    int bn, d;
    if (r) begin
      p_valid = 0; p_g = 0; m_prev = 0; m_have_ref = 0; m_faulted = 0;
      m_pos = 0; m_err = 0; m_step_err = 0; m_dir = 0; m_bout = 0; m_bvalid = 0;
      return;
    end
    m_bvalid = 0;
    if (p_valid != 0) begin
      bn       = decode(p_g);
      m_bvalid = 1;
      m_bout   = bn;
      if (!clr) begin
        if (m_have_ref == 0) begin
          m_have_ref = 1;
        end else if (m_faulted == 0) begin
          d = ((bn - m_prev) % M + M) % M;
          if (d == 1) begin
            m_pos++; m_dir = 1;
          end else if (d == M - 1) begin
            m_pos--; m_dir = 0;
          end else if (d != 0) begin
            m_step_err = 1;
            m_faulted  = 1;
            m_err      = (m_err == (1 << EW) - 1) ? m_err : m_err + 1;
          end
        end
      end
      m_prev = bn;
    end
    if (clr) begin
      m_have_ref = 0; m_faulted = 0; m_err = 0; m_step_err = 0;
    end
    p_valid = gv ? 1 : 0;
    if (gv) p_g = g;
  endtask

  task automatic step(input bit r, input bit gv, input int g, input bit clr);
    rst         = r;
    bus.g_valid = gv;
    bus.g_in    = W'(g);
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    model(r, gv, g, clr);
    chk("b_valid",  32'(bus.b_valid),  32'(m_bvalid));
    chk("b_out",    32'(bus.b_out),    32'(m_bout));
    chk("pos",      32'(bus.pos),      32'(m_pos & 32'hFFFF));
    chk("dir_up",   32'(bus.dir_up),   32'(m_dir));
    chk("step_err", 32'(bus.step_err), 32'(m_step_err));
    chk("err_cnt",  32'(bus.err_cnt),  32'(m_err));
    if (bus.b_valid === 1'b1) bv_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic sample(input int g);
    step(1'b0, 1'b1, g, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int cur, k, nb;
    bit r, gv, clr;
    rst = 1'b1;
    bus.g_valid = 1'b0;
    bus.g_in    = '0;
    bus.clr_err = 1'b0;

    // Full up-count through every code, then wrap up to zero.
    do_reset();
    chk("rst_pos", 32'(bus.pos), 32'd0);
    for (int i = 0; i < M; i++) sample(gray(i));
    sample(0);
    idle(2);
    chk("wrap_up_pos", 32'(bus.pos), 32'd16);
    chk("wrap_up_dir", 32'(bus.dir_up), 32'd1);
    chk("wrap_up_bout", 32'(bus.b_out), 32'd0);

    // Wrap down from 0 to 15.
    do_reset();
    sample(0);
    sample(8);
    idle(2);
    chk("wrap_dn_pos", 32'(bus.pos), 32'h0000FFFF);
    chk("wrap_dn_dir", 32'(bus.dir_up), 32'd0);
    chk("wrap_dn_err", 32'(bus.step_err), 32'd0);

    // Illegal step, frozen fault, then clear and resync.
    do_reset();
    sample(0);
    sample(3);
    idle(2);
    chk("ill_err", 32'(bus.step_err), 32'd1);
    chk("ill_cnt", 32'(bus.err_cnt), 32'd1);
    chk("ill_pos", 32'(bus.pos), 32'd0);
    sample(2);
    idle(2);
    chk("fault_bout", 32'(bus.b_out), 32'd3);
    chk("fault_cnt", 32'(bus.err_cnt), 32'd1);
    chk("fault_pos", 32'(bus.pos), 32'd0);
    step(1'b0, 1'b0, 0, 1'b1);
    sample(6);
    sample(7);
    idle(2);
    chk("clr_err", 32'(bus.step_err), 32'd0);
    chk("clr_cnt", 32'(bus.err_cnt), 32'd0);
    chk("clr_pos", 32'(bus.pos), 32'd1);

    // Binary 5 -> 6 is one up-step, then two holds.
    bv_count = 0;
    for (int i = 0; i < 3; i++) sample(5);
    idle(2);
    chk("hold_pulses", 32'(bv_count), 32'd3);
    chk("hold_bout", 32'(bus.b_out), 32'd6);
    chk("hold_pos", 32'(bus.pos), 32'd2);
    chk("hold_dir", 32'(bus.dir_up), 32'd1);

    // Sample coincident with reset is discarded.
    step(1'b1, 1'b1, 1, 1'b0);
    bv_count = 0;
    idle(3);
    chk("rst_drop", 32'(bv_count), 32'd0);
    chk("rst_drop_pos", 32'(bus.pos), 32'd0);

    // Random mostly-legal walk with gaps, clears and occasional resets.
    do_reset();
    cur = 0;
    for (int it = 0; it < 3000; it++) begin
      r   = ($urandom_range(0, 199) == 0);
      gv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if (gv) begin
        k = int'($urandom_range(0, 9));
        if (k < 3)      nb = cur + 1;
        else if (k < 6) nb = cur - 1;
        else if (k < 8) nb = cur;
        else            nb = int'($urandom_range(0, M - 1));
        cur = ((nb % M) + M) % M;
      end
      step(r, gv, gray(cur), clr);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
